// File: rtl/gdr_pkt_pkg.sv
// Shared PCS/gen-pkt types: control characters, 32-word PCS bundles,
// gen-pkt memory response layout and the RX checker state encoding.
package gdr_pkt_pkg;

    localparam int GEN_MEM_ADDR = 13;
    localparam int PCS_WRD_N    = 32;

    localparam logic [7:0] PCS_C_START = 8'hFB;
    localparam logic [7:0] PCS_C_END   = 8'hFD;

    typedef struct packed {
        logic [127:0] dw;
    } DWORD_128_s;

    // Word w occupies wrd[w]; byte[7] of each word is bits [63:56].
    typedef struct packed {
        logic [PCS_WRD_N-1:0][63:0] wrd;
    } PCS_D_32_WRD_s;

    // One ctl bit per byte, ctl[w][b] qualifies byte b of word w.
    typedef struct packed {
        logic [PCS_WRD_N-1:0][7:0] ctl;
    } PCS_C_32_WRD_s;

    typedef struct packed {
        DWORD_128_s [15:0] mem_data;
        logic              sop;
        logic              terminate;
    } GEN_MEM_RD_RSP_s;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_PKT  = 1'b1
    } RX_CHK_ST_e;

    // TX PCS half-word order: half-word j sits at bits [32j+31:32j].
    // Half-words 0..31 are the high halves of words 0..31, half-words
    // 32..63 the low halves of the same words.
    function automatic logic [2047:0] tpcs_remap(input PCS_D_32_WRD_s d);
        logic [2047:0] r;
        r = '0;
        for (int w = 0; w < PCS_WRD_N; w++) begin
            r[32*w +: 32]        = d.wrd[w][63:32];
            r[32*(w+32) +: 32]   = d.wrd[w][31:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/rpcs_ctl_det.sv
// Per-64b-word control detect: START in the top byte of either half-word,
// TERMINATE in any byte, both only where the byte's ctl bit is set.
module rpcs_ctl_det
    import gdr_pkt_pkg::*;
(
    input  logic [63:0] d_i,
    input  logic [7:0]  c_i,
    output logic        start_o,
    output logic        term_o
);

    // Combinational decode of one word
    always_comb begin
        start_o = (c_i[7] && (d_i[63:56] == PCS_C_START)) ||
                  (c_i[3] && (d_i[31:24] == PCS_C_START));
        term_o  = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if (c_i[b] && (d_i[8*b +: 8] == PCS_C_END)) begin
                term_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rpcs_pkt_chk.sv
// RX PCS packet checker: delineates packets on START/TERMINATE, counts and
// error-checks them, captures packet cycles into gen-pkt memory format and
// forwards a registered copy of the input as the rx_2_tx loopback source.
//
// state   | meaning
// RX_IDLE | outside a packet, waiting for START
// RX_PKT  | inside a packet, waiting for TERMINATE
module rpcs_pkt_chk
    import gdr_pkt_pkg::*;
#(
    parameter int CAP_ADDR_W = GEN_MEM_ADDR,
    parameter bit LB_EN      = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start_rx_chk,
    input  logic                  cfg_cap_en,
    input  logic [15:0]           cfg_no_of_rx_pkt,
    input  PCS_D_32_WRD_s         rdscr_rpcs_d,
    input  PCS_C_32_WRD_s         rdscr_rpcs_c,
    input  logic                  rdscr_rpcs_vld,
    output PCS_D_32_WRD_s         rpcs_tpcs_d,
    output PCS_C_32_WRD_s         rpcs_tpcs_c,
    output logic                  rpcs_tpcs_vld,
    output logic                  cap_mem_wr,
    output logic [CAP_ADDR_W-1:0] cap_mem_waddr,
    output GEN_MEM_RD_RSP_s       cap_mem_wdata,
    output logic                  cap_full,
    output logic                  inc_sop_cnt,
    output logic                  inc_term_cnt,
    output logic                  inc_pkt_cnt,
    output logic                  err_sop_in_pkt,
    output logic                  err_term_no_sop,
    output logic [15:0]           rx_pkt_cnt,
    output logic                  rx_pkt_done
);

    PCS_D_32_WRD_s         s1_d_q;
    PCS_C_32_WRD_s         s1_c_q;
    logic                  s1_vld_q;

    logic [PCS_WRD_N-1:0]  start_vec;
    logic [PCS_WRD_N-1:0]  term_vec;
    logic                  sop;
    logic                  term;
    logic                  upd;

    RX_CHK_ST_e            state_q, state_d;

    logic                  inc_sop_d, inc_term_d, inc_pkt_d;
    logic                  err_sip_d, err_tns_d, cap_wr_d;
    logic                  inc_sop_q, inc_term_q, inc_pkt_q;
    logic                  err_sip_q, err_tns_q, cap_wr_q;

    logic [15:0]           cnt_q, cnt_inc;
    logic                  done_q;

    logic [CAP_ADDR_W-1:0] ptr_q, waddr_q;
    logic                  full_q;
    GEN_MEM_RD_RSP_s       wdata_q, wdata_d;

    // S1: register the descrambler output every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_d_q   <= '0;
            s1_c_q   <= '0;
            s1_vld_q <= 1'b0;
        end else begin
            s1_d_q   <= rdscr_rpcs_d;
            s1_c_q   <= rdscr_rpcs_c;
            s1_vld_q <= rdscr_rpcs_vld;
        end
    end

    if (LB_EN) begin : g_lb
        assign rpcs_tpcs_d   = s1_d_q;
        assign rpcs_tpcs_c   = s1_c_q;
        assign rpcs_tpcs_vld = s1_vld_q;
    end else begin : g_no_lb
        assign rpcs_tpcs_d   = '0;
        assign rpcs_tpcs_c   = '0;
        assign rpcs_tpcs_vld = 1'b0;
    end

    for (genvar w = 0; w < PCS_WRD_N; w++) begin : g_det
        rpcs_ctl_det u_det (
            .d_i     (s1_d_q.wrd[w]),
            .c_i     (s1_c_q.ctl[w]),
            .start_o (start_vec[w]),
            .term_o  (term_vec[w])
        );
    end

    assign sop  = (|start_vec) & s1_vld_q;
    assign term = (|term_vec) & s1_vld_q;
    assign upd  = s1_vld_q & cfg_start_rx_chk;

    // FSM state register; disabling the checker parks it in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RX_IDLE;
        end else if (!cfg_start_rx_chk) begin
            state_q <= RX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a START+TERM cycle never changes state
    always_comb begin
        state_d = state_q;
        if (upd) begin
            case (state_q)
                RX_IDLE: if (sop && !term) state_d = RX_PKT;
                RX_PKT:  if (term && !sop) state_d = RX_IDLE;
                default: state_d = RX_IDLE;
            endcase
        end
    end

    // FSM outputs: event pulses and capture-write request for this S2 cycle
    always_comb begin
        inc_sop_d  = upd & sop;
        inc_term_d = upd & term;
        inc_pkt_d  = upd & term & (sop | (state_q == RX_PKT));
        err_sip_d  = upd & sop & ~term & (state_q == RX_PKT);
        err_tns_d  = upd & term & ~sop & (state_q == RX_IDLE);
        cap_wr_d   = upd & cfg_cap_en & ((state_q == RX_PKT) | sop) & ~full_q;
    end

    // S2 pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inc_sop_q  <= 1'b0;
            inc_term_q <= 1'b0;
            inc_pkt_q  <= 1'b0;
            err_sip_q  <= 1'b0;
            err_tns_q  <= 1'b0;
            cap_wr_q   <= 1'b0;
        end else if (!cfg_start_rx_chk) begin
            inc_sop_q  <= 1'b0;
            inc_term_q <= 1'b0;
            inc_pkt_q  <= 1'b0;
            err_sip_q  <= 1'b0;
            err_tns_q  <= 1'b0;
            cap_wr_q   <= 1'b0;
        end else begin
            inc_sop_q  <= inc_sop_d;
            inc_term_q <= inc_term_d;
            inc_pkt_q  <= inc_pkt_d;
            err_sip_q  <= err_sip_d;
            err_tns_q  <= err_tns_d;
            cap_wr_q   <= cap_wr_d;
        end
    end

    // Saturating increment; done compares against the post-increment value
    always_comb begin
        cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    end

    // Packet counter and sticky done flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (!cfg_start_rx_chk) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (inc_pkt_d) begin
            cnt_q <= cnt_inc;
            if ((cnt_inc == cfg_no_of_rx_pkt) && (cfg_no_of_rx_pkt != 16'd0)) begin
                done_q <= 1'b1;
            end
        end
    end

    // Capture word: input data in TX PCS half-word order plus delimiters
    always_comb begin
        wdata_d.mem_data  = tpcs_remap(s1_d_q);
        wdata_d.sop       = sop;
        wdata_d.terminate = term;
    end

    // Capture address/data; the last address fills the memory, no wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            waddr_q <= '0;
            full_q  <= 1'b0;
            wdata_q <= '0;
        end else if (!cfg_start_rx_chk) begin
            ptr_q   <= '0;
            waddr_q <= '0;
            full_q  <= 1'b0;
            wdata_q <= '0;
        end else if (cap_wr_d) begin
            waddr_q <= ptr_q;
            ptr_q   <= ptr_q + CAP_ADDR_W'(1);
            wdata_q <= wdata_d;
            if (&ptr_q) begin
                full_q <= 1'b1;
            end
        end
    end

    assign cap_mem_wr      = cap_wr_q;
    assign cap_mem_waddr   = waddr_q;
    assign cap_mem_wdata   = wdata_q;
    assign cap_full        = full_q;
    assign inc_sop_cnt     = inc_sop_q;
    assign inc_term_cnt    = inc_term_q;
    assign inc_pkt_cnt     = inc_pkt_q;
    assign err_sop_in_pkt  = err_sip_q;
    assign err_term_no_sop = err_tns_q;
    assign rx_pkt_cnt      = cnt_q;
    assign rx_pkt_done     = done_q;

endmodule

// File: tb/tb_rpcs_pkt_chk.sv
// Bench for rpcs_pkt_chk: directed table, capture-fill and reset sequences,
// then randomized traffic checked against a packet-level reference model.
module tb_rpcs_pkt_chk;
    import gdr_pkt_pkg::*;

    localparam int AW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            cfg_start_rx_chk, cfg_cap_en;
    logic [15:0]     cfg_no_of_rx_pkt;
    PCS_D_32_WRD_s   rdscr_rpcs_d, rpcs_tpcs_d;
    PCS_C_32_WRD_s   rdscr_rpcs_c, rpcs_tpcs_c;
    logic            rdscr_rpcs_vld, rpcs_tpcs_vld;
    logic            cap_mem_wr;
    logic [AW-1:0]   cap_mem_waddr;
    GEN_MEM_RD_RSP_s cap_mem_wdata;
    logic            cap_full, inc_sop_cnt, inc_term_cnt, inc_pkt_cnt;
    logic            err_sop_in_pkt, err_term_no_sop, rx_pkt_done;
    logic [15:0]     rx_pkt_cnt;

    always #5 clk = ~clk;

    rpcs_pkt_chk #(.CAP_ADDR_W(AW), .LB_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .cfg_start_rx_chk(cfg_start_rx_chk), .cfg_cap_en(cfg_cap_en),
        .cfg_no_of_rx_pkt(cfg_no_of_rx_pkt),
        .rdscr_rpcs_d(rdscr_rpcs_d), .rdscr_rpcs_c(rdscr_rpcs_c), .rdscr_rpcs_vld(rdscr_rpcs_vld),
        .rpcs_tpcs_d(rpcs_tpcs_d), .rpcs_tpcs_c(rpcs_tpcs_c), .rpcs_tpcs_vld(rpcs_tpcs_vld),
        .cap_mem_wr(cap_mem_wr), .cap_mem_waddr(cap_mem_waddr), .cap_mem_wdata(cap_mem_wdata),
        .cap_full(cap_full), .inc_sop_cnt(inc_sop_cnt), .inc_term_cnt(inc_term_cnt),
        .inc_pkt_cnt(inc_pkt_cnt), .err_sop_in_pkt(err_sop_in_pkt),
        .err_term_no_sop(err_term_no_sop), .rx_pkt_cnt(rx_pkt_cnt), .rx_pkt_done(rx_pkt_done)
    );

    typedef struct {
        bit            vld;
        PCS_D_32_WRD_s d;
        PCS_C_32_WRD_s c;
    } in_t;

    typedef struct {
        bit            sop, term, pkt, esip, etns, wr, full, done;
        logic [15:0]   cnt;
        logic [AW-1:0] waddr;
        logic [2049:0] wdata;
    } exp_t;

    typedef struct {
        bit vld, st, tm;
        bit sop, term, pkt, esip, etns, done;
        int cnt;
    } vec_t;

    vec_t tab[$];

    int n_vec = 0;
    int n_err = 0;

    // reference model state: packet-level view
    bit  m_pkt, m_done, m_full;
    int  m_cnt, m_ptr;

    in_t           pend;
    int            pend_row;
    int            wr_seen;
    logic [AW-1:0] last_waddr;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, a, e, $time);
        end
    endtask

    task automatic chk_wide(input string nm, input logic [2111:0] a, input logic [2111:0] e);
        int idx;
        idx = 0;
        for (int i = 0; i < 33; i++) begin
            if (a[i*64 +: 64] !== e[i*64 +: 64]) begin
                idx = i;
                break;
            end
        end
        chk($sformatf("%s_w%0d", nm, idx), a[idx*64 +: 64], e[idx*64 +: 64]);
    endtask

    function automatic in_t idle();
        in_t x;
        x.vld = 1'b0;
        x.d   = '0;
        x.c   = '0;
        return x;
    endfunction

    function automatic exp_t no_exp();
        exp_t e;
        e.sop = 0; e.term = 0; e.pkt = 0; e.esip = 0; e.etns = 0;
        e.wr = 0; e.full = 0; e.done = 0;
        e.cnt = '0; e.waddr = '0; e.wdata = '0;
        return e;
    endfunction

    // Random cycle: background never forms a qualified START/END; decoys
    // (unqualified or START in a non-top byte) are left in on purpose.
    function automatic in_t gen(input bit vld, input bit st, input bit tm);
        in_t x;
        int ws, bs, wt, bt;
        logic [7:0] by;
        x.vld = vld;
        for (int w = 0; w < 32; w++) begin
            for (int b = 0; b < 8; b++) begin
                by = 8'($urandom);
                if ($urandom_range(0, 15) == 0) by = ($urandom_range(0, 1) == 1) ? PCS_C_START : PCS_C_END;
                x.c.ctl[w][b] = ($urandom_range(0, 7) == 0);
                if (x.c.ctl[w][b] && (by == PCS_C_END || (by == PCS_C_START && (b == 3 || b == 7))))
                    by = 8'h07;
                x.d.wrd[w][8*b +: 8] = by;
            end
        end
        ws = 0;
        if (st) begin
            ws = $urandom_range(0, 31);
            bs = ($urandom_range(0, 1) == 1) ? 7 : 3;
            x.d.wrd[ws][8*bs +: 8] = PCS_C_START;
            x.c.ctl[ws][bs] = 1'b1;
        end
        if (tm) begin
            wt = $urandom_range(0, 31);
            if (st && wt == ws) wt = (wt + 1) % 32;
            bt = $urandom_range(0, 7);
            x.d.wrd[wt][8*bt +: 8] = PCS_C_END;
            x.c.ctl[wt][bt] = 1'b1;
        end
        return x;
    endfunction

    // START: qualified FB at the top byte of a 32b half-word; END: qualified FD anywhere
    task automatic detect(input in_t x, output bit sop, output bit term);
        logic [7:0] by;
        sop = 0;
        term = 0;
        for (int w = 0; w < 32; w++) begin
            for (int b = 0; b < 8; b++) begin
                by = x.d.wrd[w][8*b +: 8];
                if (x.c.ctl[w][b]) begin
                    if (by == PCS_C_END) term = 1;
                    if (by == PCS_C_START && (b % 4 == 3)) sop = 1;
                end
            end
        end
    endtask

    function automatic logic [2049:0] exp_wdata(input in_t x, input bit sop, input bit term);
        logic [2049:0] r;
        logic [63:0]   wd;
        r = '0;
        for (int j = 0; j < 64; j++) begin
            wd = x.d.wrd[j % 32];
            r[2 + 32*j +: 32] = (j < 32) ? wd[63:32] : wd[31:0];
        end
        r[1] = sop;
        r[0] = term;
        return r;
    endfunction

    task automatic complete_pkt();
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt == int'(cfg_no_of_rx_pkt) && cfg_no_of_rx_pkt != 16'd0) m_done = 1;
    endtask

    task automatic model_step(input in_t x, output exp_t e);
        bit sop, term, wr;
        e = no_exp();
        if (!cfg_start_rx_chk) begin
            m_pkt = 0; m_cnt = 0; m_done = 0; m_full = 0; m_ptr = 0;
            return;
        end
        detect(x, sop, term);
        if (!x.vld) begin
            sop = 0;
            term = 0;
        end
        wr = x.vld && cfg_cap_en && (m_pkt || sop) && !m_full;
        if (wr) begin
            e.wr    = 1;
            e.waddr = AW'(m_ptr);
            e.wdata = exp_wdata(x, sop, term);
            if (m_ptr == (1 << AW) - 1) m_full = 1;
            m_ptr++;
        end
        if (sop && term) begin
            complete_pkt();
            e.pkt = 1;
        end else if (sop) begin
            if (m_pkt) e.esip = 1;
            m_pkt = 1;
        end else if (term) begin
            if (m_pkt) begin
                complete_pkt();
                e.pkt = 1;
            end else begin
                e.etns = 1;
            end
            m_pkt = 0;
        end
        e.sop  = sop;
        e.term = term;
        e.cnt  = 16'(m_cnt);
        e.done = m_done;
        e.full = m_full;
    endtask

    task automatic check_out(input exp_t e);
        chk("inc_sop", 64'(inc_sop_cnt), 64'(e.sop));
        chk("inc_term", 64'(inc_term_cnt), 64'(e.term));
        chk("inc_pkt", 64'(inc_pkt_cnt), 64'(e.pkt));
        chk("err_sop_in_pkt", 64'(err_sop_in_pkt), 64'(e.esip));
        chk("err_term_no_sop", 64'(err_term_no_sop), 64'(e.etns));
        chk("rx_pkt_cnt", 64'(rx_pkt_cnt), 64'(e.cnt));
        chk("rx_pkt_done", 64'(rx_pkt_done), 64'(e.done));
        chk("cap_wr", 64'(cap_mem_wr), 64'(e.wr));
        chk("cap_full", 64'(cap_full), 64'(e.full));
        if (e.wr) begin
            chk("cap_waddr", 64'(cap_mem_waddr), 64'(e.waddr));
            chk_wide("cap_wdata", {62'b0, cap_mem_wdata}, {62'b0, e.wdata});
        end
    endtask

    task automatic check_tab(input vec_t v);
        chk("tab_inc_sop", 64'(inc_sop_cnt), 64'(v.sop));
        chk("tab_inc_term", 64'(inc_term_cnt), 64'(v.term));
        chk("tab_inc_pkt", 64'(inc_pkt_cnt), 64'(v.pkt));
        chk("tab_err_sop_in_pkt", 64'(err_sop_in_pkt), 64'(v.esip));
        chk("tab_err_term_no_sop", 64'(err_term_no_sop), 64'(v.etns));
        chk("tab_rx_pkt_cnt", 64'(rx_pkt_cnt), 64'(v.cnt));
        chk("tab_rx_pkt_done", 64'(rx_pkt_done), 64'(v.done));
    endtask

    task automatic check_lb(input in_t x);
        chk("lb_vld", 64'(rpcs_tpcs_vld), 64'(x.vld));
        chk_wide("lb_c", {1856'b0, rpcs_tpcs_c}, {1856'b0, x.c});
        chk_wide("lb_d", {64'b0, rpcs_tpcs_d}, {64'b0, x.d});
    endtask

    // Drive one input cycle; after the edge the S2 outputs belong to the
    // previous input and the loopback to this one.
    task automatic step(input in_t x, input int row);
        exp_t e;
        rdscr_rpcs_d   = x.d;
        rdscr_rpcs_c   = x.c;
        rdscr_rpcs_vld = x.vld;
        model_step(pend, e);
        @(posedge clk);
        #1;
        if (pend_row >= 0) check_tab(tab[pend_row]);
        else               check_out(e);
        check_lb(x);
        if (cap_mem_wr) begin
            wr_seen++;
            last_waddr = cap_mem_waddr;
        end
        pend     = x;
        pend_row = row;
    endtask

    task automatic add(input bit vld, st, tm, sop, term, pkt, esip, etns, done, input int cnt);
        vec_t v;
        v.vld = vld; v.st = st; v.tm = tm;
        v.sop = sop; v.term = term; v.pkt = pkt; v.esip = esip; v.etns = etns;
        v.done = done; v.cnt = cnt;
        tab.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cfg_start_rx_chk = 1'b0;
        cfg_cap_en = 1'b0;
        cfg_no_of_rx_pkt = 16'd0;
        rdscr_rpcs_d = '0;
        rdscr_rpcs_c = '0;
        rdscr_rpcs_vld = 1'b0;
        m_pkt = 0; m_done = 0; m_full = 0; m_cnt = 0; m_ptr = 0;
        pend = idle();
        pend_row = -1;
        wr_seen = 0;
        last_waddr = '0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_out(no_exp());
        check_lb(idle());
        @(negedge clk);
        rst = 1'b0;

        // directed table: vld, st, tm | sop, term, pkt, esip, etns, done, cnt
        cfg_start_rx_chk = 1'b1;
        cfg_no_of_rx_pkt = 16'd3;
        add(1,1,0, 1,0,0,0,0,0,0);
        add(1,0,0, 0,0,0,0,0,0,0);
        add(1,0,0, 0,0,0,0,0,0,0);
        add(1,0,1, 0,1,1,0,0,0,1);
        add(1,1,0, 1,0,0,0,0,0,1);
        add(0,1,1, 0,0,0,0,0,0,1);
        add(1,0,0, 0,0,0,0,0,0,1);
        add(1,0,1, 0,1,1,0,0,0,2);
        add(1,1,0, 1,0,0,0,0,0,2);
        add(1,0,0, 0,0,0,0,0,0,2);
        add(1,0,0, 0,0,0,0,0,0,2);
        add(1,0,1, 0,1,1,0,0,1,3);
        add(1,1,1, 1,1,1,0,0,1,4);
        add(1,0,1, 0,1,0,0,1,1,4);
        add(1,1,0, 1,0,0,0,0,1,4);
        add(1,1,0, 1,0,0,1,0,1,4);
        add(1,1,1, 1,1,1,0,0,1,5);
        add(1,0,1, 0,1,1,0,0,1,6);
        add(1,0,1, 0,1,0,0,1,1,6);
        add(1,0,0, 0,0,0,0,0,1,6);
        for (int i = 0; i < tab.size(); i++) step(gen(tab[i].vld, tab[i].st, tab[i].tm), i);
        step(idle(), -1);

        // capture fill: 20-cycle packet into a 16-entry memory
        cfg_start_rx_chk = 1'b0;
        step(idle(), -1);
        cfg_start_rx_chk = 1'b1;
        cfg_cap_en = 1'b1;
        wr_seen = 0;
        step(gen(1, 1, 0), -1);
        for (int i = 0; i < 18; i++) step(gen(1, 0, 0), -1);
        step(gen(1, 0, 1), -1);
        step(idle(), -1);
        step(idle(), -1);
        chk("cap_writes", 64'(wr_seen), 64'd16);
        chk("cap_last_addr", 64'(last_waddr), 64'd15);
        chk("cap_full_set", 64'(cap_full), 64'd1);
        cfg_start_rx_chk = 1'b0;
        step(idle(), -1);
        chk("clr_waddr", 64'(cap_mem_waddr), 64'd0);
        chk("clr_full", 64'(cap_full), 64'd0);
        cfg_start_rx_chk = 1'b1;

        // async reset in the middle of a packet
        step(gen(1, 1, 0), -1);
        step(gen(1, 0, 0), -1);
        step(gen(1, 0, 0), -1);
        #3;
        rst = 1'b1;
        #1;
        check_out(no_exp());
        check_lb(idle());
        @(negedge clk);
        rst = 1'b0;
        m_pkt = 0; m_done = 0; m_full = 0; m_cnt = 0; m_ptr = 0;
        pend = idle();
        pend_row = -1;
        step(gen(1, 0, 1), -1);
        step(idle(), -1);
        chk("rst_then_term_err", 64'(err_term_no_sop), 64'd1);

        // randomized traffic with vld gaps and periodic disable
        cfg_no_of_rx_pkt = 16'd4;
        for (int i = 0; i < 400; i++) begin
            cfg_start_rx_chk = (i % 80 != 79);
            cfg_cap_en = (i % 160 < 120);
            step(gen($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0), -1);
        end
        step(idle(), -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
